// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared frontend types for the fetch sequencer: FSM states, redirect sources
// and the redirect priority encoder.
package fetch_redirect_ctrl_pkg;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } fetch_state_e;

  typedef enum logic [2:0] {
    REDIR_NONE,
    REDIR_BP,
    REDIR_REPLAY,
    REDIR_MISPREDICT,
    REDIR_FLUSH
  } redirect_src_e;

  // Backend flush outranks mispredict, which outranks queue replay, then prediction.
  function automatic redirect_src_e pick_redirect(input logic flush,
                                                  input logic mispredict,
                                                  input logic replay,
                                                  input logic bp);
    if (flush) return REDIR_FLUSH;
    if (mispredict) return REDIR_MISPREDICT;
    if (replay) return REDIR_REPLAY;
    if (bp) return REDIR_BP;
    return REDIR_NONE;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_inflight_tracker.sv
// In-flight ICache request tracker: outstanding count, stale-response drop
// count and the filtered response valid. Optional FETCH_CTRL_PERF_EN adds a drop strobe.
module fetch_inflight_tracker
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             accept_i,
  input  logic             rsp_valid_i,
  input  logic             redirect_i,
  input  logic             kill_s2_i,
  output logic             can_issue_c,
  output logic             resp_valid_c,
`ifdef FETCH_CTRL_PERF_EN
  output logic             drop_hit_c,
`endif
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             drop_pending;

  assign drop_pending = (drop_q != '0);
  assign can_issue_c  = (cnt_q < CNT_W'(MAX_OUTSTANDING)) || rsp_valid_i;
  assign resp_valid_c = rsp_valid_i && !drop_pending && !kill_s2_i;
  assign cnt_o        = cnt_q;
`ifdef FETCH_CTRL_PERF_EN
  assign drop_hit_c   = rsp_valid_i && drop_pending;
`endif

  // Every request still owed by the ICache at a redirect, including one accepted
  // in the redirect cycle itself, returns a response that must be discarded.
  always_comb begin
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (accept_i && !rsp_valid_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept_i && rsp_valid_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (redirect_i) begin
      drop_d = cnt_q - CNT_W'(rsp_valid_i) + CNT_W'(accept_i);
    end else if (drop_pending && rsp_valid_i) begin
      drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch sequencer: next-PC register, prioritised redirect selection and ICache
// request/kill/speculation control. Optional FETCH_CTRL_PERF_EN adds perf counters.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned VLEN             = 32,
  parameter int unsigned FETCH_ALIGN_BITS = 2,
  parameter int unsigned MAX_OUTSTANDING  = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [VLEN-1:0] boot_addr_i,
  input  logic            flush_i,
  input  logic [VLEN-1:0] flush_target_i,
  input  logic            mispredict_i,
  input  logic [VLEN-1:0] mispredict_target_i,
  input  logic            replay_i,
  input  logic [VLEN-1:0] replay_addr_i,
  input  logic            bp_valid_i,
  input  logic [VLEN-1:0] bp_target_i,
  input  logic            resolve_valid_i,
  input  logic            halt_i,
  input  logic            queue_ready_i,
  input  logic            icache_ready_i,
  input  logic            icache_valid_i,
  output logic            icache_req_o,
  output logic [VLEN-1:0] icache_vaddr_o,
  output logic            kill_s1_o,
  output logic            kill_s2_o,
  output logic            spec_o,
  output logic            resp_valid_o,
`ifdef FETCH_CTRL_PERF_EN
  output logic [31:0]     perf_redirect_o,
  output logic [31:0]     perf_drop_o,
  output logic [31:0]     perf_stall_o,
`endif
  output logic [2:0]      outstanding_o
);

  localparam logic [VLEN-1:0] BLK_BYTES  = VLEN'(1) << FETCH_ALIGN_BITS;
  localparam logic [VLEN-1:0] ALIGN_MASK = ~(BLK_BYTES - VLEN'(1));

  fetch_state_e    state_q, state_d;
  logic [VLEN-1:0] npc_q, npc_d;
  logic            spec_q, spec_d;
  redirect_src_e   redir_src;
  logic            redirect_act;
  logic            accept;
  logic            can_issue;
  logic [VLEN-1:0] fetch_next;
  logic [CNT_W-1:0] cnt;
`ifdef FETCH_CTRL_PERF_EN
  logic            drop_hit;
`endif

  assign redir_src    = pick_redirect(flush_i, mispredict_i, replay_i, bp_valid_i);
  assign redirect_act = (redir_src != REDIR_NONE) && (state_q != ST_BOOT);
  assign accept       = icache_req_o && icache_ready_i;
  assign fetch_next   = (icache_vaddr_o & ALIGN_MASK) + BLK_BYTES;
  assign spec_o       = spec_q || bp_valid_i;
  assign outstanding_o = cnt;

  fetch_inflight_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_tracker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .accept_i    (accept),
    .rsp_valid_i (icache_valid_i),
    .redirect_i  (redirect_act),
    .kill_s2_i   (kill_s2_o),
    .can_issue_c (can_issue),
    .resp_valid_c(resp_valid_o),
`ifdef FETCH_CTRL_PERF_EN
    .drop_hit_c  (drop_hit),
`endif
    .cnt_o       (cnt)
  );

  // Next state, next PC, speculation flag and the combinational request/kill outputs.
  always_comb begin
    state_d        = state_q;
    npc_d          = npc_q;
    spec_d         = spec_q;
    kill_s1_o      = flush_i || mispredict_i || replay_i;
    kill_s2_o      = flush_i || mispredict_i || replay_i || bp_valid_i;
    icache_vaddr_o = (redir_src == REDIR_BP) ? bp_target_i : npc_q;
    icache_req_o   = (state_q == ST_RUN) && queue_ready_i && !halt_i && can_issue;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        npc_d   = boot_addr_i;
      end
      ST_RUN:  if (halt_i) state_d = ST_HALT;
      ST_HALT: if (!halt_i) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    if (state_q != ST_BOOT) begin
      unique case (redir_src)
        REDIR_FLUSH:      npc_d = flush_target_i;
        REDIR_MISPREDICT: npc_d = mispredict_target_i;
        REDIR_REPLAY:     npc_d = replay_addr_i;
        REDIR_BP:         npc_d = accept ? fetch_next : bp_target_i;
        REDIR_NONE:       if (accept) npc_d = fetch_next;
        default:          npc_d = npc_q;
      endcase
    end

    if (flush_i) begin
      spec_d = 1'b0;
    end else if (bp_valid_i) begin
      spec_d = 1'b1;
    end else if (resolve_valid_i) begin
      spec_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_BOOT;
      npc_q   <= '0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      npc_q   <= npc_d;
      spec_q  <= spec_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_redirect_o <= '0;
      perf_drop_o     <= '0;
      perf_stall_o    <= '0;
    end else begin
      if (redirect_act && (perf_redirect_o != '1)) perf_redirect_o <= perf_redirect_o + 32'd1;
      if (drop_hit && (perf_drop_o != '1)) perf_drop_o <= perf_drop_o + 32'd1;
      if ((state_q == ST_RUN) && !icache_req_o && (perf_stall_o != '1)) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: boot sequencing, outstanding limit,
// stale-response dropping, redirect priority, halt and speculation tracking.
module tb_fetch_redirect_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] boot_addr_i;
  logic        flush_i, mispredict_i, replay_i, bp_valid_i;
  logic [31:0] flush_target_i, mispredict_target_i, replay_addr_i, bp_target_i;
  logic        resolve_valid_i, halt_i, queue_ready_i, icache_ready_i, icache_valid_i;
  logic        icache_req_o, kill_s1_o, kill_s2_o, spec_o, resp_valid_o;
  logic [31:0] icache_vaddr_o;
  logic [2:0]  outstanding_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  fetch_redirect_ctrl #(
    .VLEN(32), .FETCH_ALIGN_BITS(2), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .boot_addr_i        (boot_addr_i),
    .flush_i            (flush_i),
    .flush_target_i     (flush_target_i),
    .mispredict_i       (mispredict_i),
    .mispredict_target_i(mispredict_target_i),
    .replay_i           (replay_i),
    .replay_addr_i      (replay_addr_i),
    .bp_valid_i         (bp_valid_i),
    .bp_target_i        (bp_target_i),
    .resolve_valid_i    (resolve_valid_i),
    .halt_i             (halt_i),
    .queue_ready_i      (queue_ready_i),
    .icache_ready_i     (icache_ready_i),
    .icache_valid_i     (icache_valid_i),
    .icache_req_o       (icache_req_o),
    .icache_vaddr_o     (icache_vaddr_o),
    .kill_s1_o          (kill_s1_o),
    .kill_s2_o          (kill_s2_o),
    .spec_o             (spec_o),
    .resp_valid_o       (resp_valid_o),
    .outstanding_o      (outstanding_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    boot_addr_i = 32'h1000;
    flush_i = 1'b0; mispredict_i = 1'b0; replay_i = 1'b0; bp_valid_i = 1'b0;
    flush_target_i = '0; mispredict_target_i = '0; replay_addr_i = '0; bp_target_i = '0;
    resolve_valid_i = 1'b0; halt_i = 1'b0; icache_valid_i = 1'b0;
    queue_ready_i = 1'b1; icache_ready_i = 1'b1;
    #2;
    chk("rst_req", 32'(icache_req_o), 32'd0);
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_kill_s1", 32'(kill_s1_o), 32'd0);
    chk("rst_kill_s2", 32'(kill_s2_o), 32'd0);
    chk("rst_spec", 32'(spec_o), 32'd0);

    tick(); tick();
    rst_i = 1'b0; #1;
    chk("boot_no_req", 32'(icache_req_o), 32'd0);

    // Sequential fetch from boot address, one response per cycle after the first.
    tick();
    chk("seq0_req", 32'(icache_req_o), 32'd1);
    chk("seq0_addr", icache_vaddr_o, 32'h1000);
    tick();
    icache_valid_i = 1'b1; #1;
    chk("seq1_addr", icache_vaddr_o, 32'h1004);
    chk("seq1_req", 32'(icache_req_o), 32'd1);
    chk("seq1_resp", 32'(resp_valid_o), 32'd1);
    tick();
    chk("seq2_addr", icache_vaddr_o, 32'h1008);
    chk("seq2_req", 32'(icache_req_o), 32'd1);

    // Fill to the outstanding limit, then release with a same-cycle response.
    tick();
    icache_valid_i = 1'b0; #1;
    chk("fill_req", 32'(icache_req_o), 32'd1);
    tick();
    chk("full_outstanding", 32'(outstanding_o), 32'd2);
    chk("full_block", 32'(icache_req_o), 32'd0);
    icache_valid_i = 1'b1; #1;
    chk("full_rsp_reenable", 32'(icache_req_o), 32'd1);

    // Mispredict with two in flight: two stale responses dropped, third passes.
    tick();
    icache_valid_i = 1'b0; mispredict_i = 1'b1; mispredict_target_i = 32'h2000; #1;
    chk("misp_kill_s1", 32'(kill_s1_o), 32'd1);
    chk("misp_no_req", 32'(icache_req_o), 32'd0);
    tick();
    mispredict_i = 1'b0; icache_valid_i = 1'b1; #1;
    chk("misp_vaddr", icache_vaddr_o, 32'h2000);
    chk("stale0_resp", 32'(resp_valid_o), 32'd0);
    tick();
    chk("stale1_resp", 32'(resp_valid_o), 32'd0);
    tick();
    chk("fresh_resp", 32'(resp_valid_o), 32'd1);
    chk("fresh_outstanding", 32'(outstanding_o), 32'd2);

    // Simultaneous flush, replay and prediction: flush wins and clears speculation.
    tick();
    icache_valid_i = 1'b0;
    flush_i = 1'b1; flush_target_i = 32'h80;
    replay_i = 1'b1; replay_addr_i = 32'h3000;
    bp_valid_i = 1'b1; bp_target_i = 32'h4000; #1;
    chk("prio_kill_s1", 32'(kill_s1_o), 32'd1);
    chk("prio_kill_s2", 32'(kill_s2_o), 32'd1);
    tick();
    flush_i = 1'b0; replay_i = 1'b0; bp_valid_i = 1'b0; icache_valid_i = 1'b1; #1;
    chk("prio_vaddr", icache_vaddr_o, 32'h80);
    chk("flush_bp_spec", 32'(spec_o), 32'd0);
    tick();
    tick();
    chk("post_flush_resp", 32'(resp_valid_o), 32'd1);
    tick();
    queue_ready_i = 1'b0;

    // Halt for five cycles with one request in flight.
    tick();
    queue_ready_i = 1'b1; icache_valid_i = 1'b0; halt_i = 1'b1; #1;
    chk("halt_outstanding", 32'(outstanding_o), 32'd1);
    chk("halt0_req", 32'(icache_req_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      icache_valid_i = (i == 1); #1;
      chk("halt_req", 32'(icache_req_o), 32'd0);
      if (i == 1) chk("halt_resp", 32'(resp_valid_o), 32'd1);
    end
    tick();
    halt_i = 1'b0; icache_valid_i = 1'b0; #1;
    chk("unhalt_req", 32'(icache_req_o), 32'd0);
    chk("unhalt_outstanding", 32'(outstanding_o), 32'd0);
    tick();
    chk("resume_req", 32'(icache_req_o), 32'd1);
    chk("resume_addr", icache_vaddr_o, 32'h8C);

    // Prediction followed by resolve.
    queue_ready_i = 1'b0; bp_valid_i = 1'b1; bp_target_i = 32'h4000; #1;
    chk("bp_spec", 32'(spec_o), 32'd1);
    chk("bp_kill_s2", 32'(kill_s2_o), 32'd1);
    chk("bp_kill_s1", 32'(kill_s1_o), 32'd0);
    chk("bp_vaddr", icache_vaddr_o, 32'h4000);
    tick();
    bp_valid_i = 1'b0; #1;
    chk("spec_held", 32'(spec_o), 32'd1);
    chk("bp_npc", icache_vaddr_o, 32'h4000);
    tick();
    resolve_valid_i = 1'b1; #1;
    chk("spec_resolve_cycle", 32'(spec_o), 32'd1);

    // Redirect with a same-cycle accepted request, then address wrap.
    tick();
    resolve_valid_i = 1'b0; queue_ready_i = 1'b1;
    mispredict_i = 1'b1; mispredict_target_i = 32'hFFFF_FFFC; #1;
    chk("spec_cleared", 32'(spec_o), 32'd0);
    chk("redir_accept_req", 32'(icache_req_o), 32'd1);
    tick();
    mispredict_i = 1'b0; icache_valid_i = 1'b1; #1;
    chk("wrap_base", icache_vaddr_o, 32'hFFFF_FFFC);
    chk("killed_resp_drop", 32'(resp_valid_o), 32'd0);
    tick();
    chk("wrap_addr", icache_vaddr_o, 32'h0);
    chk("wrap_resp", 32'(resp_valid_o), 32'd1);

    // Asynchronous reset mid-operation.
    rst_i = 1'b1; #1;
    chk("async_rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("async_rst_req", 32'(icache_req_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
